// File: rtl/layer_arb_pkg.sv
// layer_arb_pkg: shared types for the two-requester layer arbiter.
// Holds the arbiter FSM state type and the stats counter width.
package layer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/layer_arb_rr.sv
// layer_arb_rr: combinational 2-way round-robin picker.
// Ports: req[1:0] requests, last previous winner -> gnt winner, any request.
module layer_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  assign any = |req;

  // On a tie the port that did not win last time is picked.
  assign gnt = (&req) ? ~last : req[1];

endmodule

// File: rtl/layer_arb2.sv
// layer_arb2: time-shares one layer engine between two requesters.
// Ports: clk, reset (async active-low), s0/s1 in streams, m0/m1 result
// streams, e_* engine side; LAYER_ARB2_STATS_EN adds done_cnt0/done_cnt1.
module layer_arb2
  import layer_arb_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8,
  parameter int T = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [T-1:0] s0_data,
  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic [T-1:0] s1_data,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [T-1:0] m0_data,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [T-1:0] m1_data,
  output logic         e_s_valid,
  input  logic         e_s_ready,
  output logic [T-1:0] e_data_in,
  input  logic         e_m_valid,
  output logic         e_m_ready,
  input  logic [T-1:0] e_data_out
`ifdef LAYER_ARB2_STATS_EN
  ,
  output logic [STAT_W-1:0] done_cnt0,
  output logic [STAT_W-1:0] done_cnt1
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] IN_LAST = IW'(N - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(M - 1);

  arb_state_t    state;
  logic          grant;
  logic          last_grant;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;

  logic pick;
  logic any;
  logic in_hs;
  logic out_hs;
  logic vec_done;

  layer_arb_rr u_rr (
    .req  ({s1_valid, s0_valid}),
    .last (last_grant),
    .gnt  (pick),
    .any  (any)
  );

  always_comb begin
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    e_s_valid = 1'b0;
    e_data_in = '0;
    m0_valid  = 1'b0;
    m1_valid  = 1'b0;
    m0_data   = '0;
    m1_data   = '0;
    e_m_ready = 1'b0;
    unique case (1'b1)
      (state == LOAD): begin
        e_s_valid = grant ? s1_valid : s0_valid;
        e_data_in = grant ? s1_data : s0_data;
        s0_ready  = ~grant & e_s_ready;
        s1_ready  = grant & e_s_ready;
      end
      (state == DRAIN): begin
        m0_valid  = ~grant & e_m_valid;
        m1_valid  = grant & e_m_valid;
        m0_data   = grant ? '0 : e_data_out;
        m1_data   = grant ? e_data_out : '0;
        e_m_ready = grant ? m1_ready : m0_ready;
      end
      default: begin
      end
    endcase
  end

  assign in_hs    = e_s_valid & e_s_ready;
  assign out_hs   = e_m_valid & e_m_ready;
  assign vec_done = out_hs & (out_cnt == OUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (any) begin
            grant <= pick;
            state <= LOAD;
          end
        end
        (state == LOAD): begin
          if (in_hs) begin
            if (in_cnt == IN_LAST) begin
              in_cnt <= '0;
              state  <= DRAIN;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        (state == DRAIN): begin
          if (vec_done) begin
            out_cnt    <= '0;
            last_grant <= grant;
            state      <= IDLE;
          end else if (out_hs) begin
            out_cnt <= out_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAYER_ARB2_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (vec_done) begin
      if (!grant && done_cnt0 != '1)
        done_cnt0 <= done_cnt0 + 1'b1;
      if (grant && done_cnt1 != '1)
        done_cnt1 <= done_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_arb2.sv
// tb_layer_arb2: directed bench for layer_arb2 with a transaction model,
// a bench-side engine, and a per-cycle compare process.
module tb_layer_arb2;

  localparam int M = 8;
  localparam int N = 8;
  localparam int T = 8;

  logic clk = 0;
  logic reset;
  logic s0_valid, s0_ready, s1_valid, s1_ready;
  logic [T-1:0] s0_data, s1_data;
  logic m0_valid, m0_ready, m1_valid, m1_ready;
  logic [T-1:0] m0_data, m1_data;
  logic e_s_valid, e_s_ready, e_m_valid, e_m_ready;
  logic [T-1:0] e_data_in, e_data_out;
`ifdef LAYER_ARB2_STATS_EN
  logic [15:0] done_cnt0, done_cnt1;
`endif

  always #5 clk = ~clk;

  layer_arb2 #(.M(M), .N(N), .T(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s0_data    (s0_data),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .s1_data    (s1_data),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_data    (m0_data),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_data    (m1_data),
    .e_s_valid  (e_s_valid),
    .e_s_ready  (e_s_ready),
    .e_data_in  (e_data_in),
    .e_m_valid  (e_m_valid),
    .e_m_ready  (e_m_ready),
    .e_data_out (e_data_out)
`ifdef LAYER_ARB2_STATS_EN
    ,
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  wire [1:0] sv = {s1_valid, s0_valid};
  wire [1:0] sr = {s1_ready, s0_ready};
  wire [1:0] mv = {m1_valid, m0_valid};
  wire [1:0] mr = {m1_ready, m0_ready};
  wire [5:0] all_hs = {s0_ready, s1_ready, m0_valid,
                       m1_valid, e_s_valid, e_m_ready};

  // Source queues, scoreboards, serve order log.
  logic [T-1:0] sq0[$], sq1[$], exp0[$], exp1[$], rxq0[$], rxq1[$];
  int order[$];
  bit hold0, hold1;
  int txc0 = 0, txc1 = 0, rxc0 = 0, rxc1 = 0;

  // Transaction model: which port owns the engine and how far it got.
  int mp = -1;
  int last_p = 1;
  bit ph_load = 0;
  int nin = 0, nout = 0;
  int dn0 = 0, dn1 = 0;
  logic [T-1:0] got;

  always @(negedge clk) begin
    if (!reset) begin
      mp = -1;
      last_p = 1;
      ph_load = 0;
      dn0 = 0;
      dn1 = 0;
    end else if (mp < 0) begin
      chk("idle_s_ready", sr, 0);
      chk("idle_e_s_valid", e_s_valid, 0);
      chk("idle_m_valid", mv, 0);
      chk("idle_e_m_ready", e_m_ready, 0);
      if (|sv) begin
        mp = (&sv) ? 1 - last_p : (sv[1] ? 1 : 0);
        ph_load = 1;
        nin = 0;
        order.push_back(mp);
      end
    end else if (ph_load) begin
      chk("load_e_s_valid", e_s_valid, sv[mp]);
      chk("load_e_data_in", e_data_in, mp ? s1_data : s0_data);
      chk("load_s_ready", sr[mp], e_s_ready);
      chk("load_other_ready", sr[1-mp], 0);
      chk("load_m_valid", mv, 0);
      chk("load_e_m_ready", e_m_ready, 0);
      if (sv[mp] && e_s_ready) begin
        if (mp == 1) txc1++;
        else txc0++;
        nin++;
        if (nin == N) begin
          ph_load = 0;
          nout = 0;
        end
      end
    end else begin
      chk("drain_m_valid", mv[mp], e_m_valid);
      chk("drain_m_data", mp ? m1_data : m0_data, e_data_out);
      chk("drain_e_m_ready", e_m_ready, mr[mp]);
      chk("drain_other_valid", mv[1-mp], 0);
      chk("drain_other_data", mp ? m0_data : m1_data, 0);
      chk("drain_s_ready", sr, 0);
      chk("drain_e_s_valid", e_s_valid, 0);
      if (e_m_valid && mr[mp]) begin
        got = mp ? m1_data : m0_data;
        if (mp == 1) begin
          rxc1++;
          rxq1.push_back(got);
          if (exp1.size() == 0) chk("sb_extra1", 1, 0);
          else chk("sb_m1", got, exp1.pop_front());
        end else begin
          rxc0++;
          rxq0.push_back(got);
          if (exp0.size() == 0) chk("sb_extra0", 1, 0);
          else chk("sb_m0", got, exp0.pop_front());
        end
        nout++;
        if (nout == M) begin
          if (mp == 1) dn1++;
          else dn0++;
          last_p = mp;
          mp = -1;
        end
      end
    end
  end

  // Bench engine: buffers a full vector, then returns word+0x10 per word.
  logic [T-1:0] ebuf[$];
  int ek = 0;
  bit ehi, eho;
  logic [T-1:0] edi;

  initial begin
    e_s_ready = 0;
    e_m_valid = 0;
    e_data_out = '0;
    forever begin
      @(negedge clk);
      ehi = e_s_valid && e_s_ready;
      edi = e_data_in;
      eho = e_m_valid && e_m_ready;
      @(posedge clk);
      #2;
      if (!reset) begin
        ebuf.delete();
        ek = 0;
      end else begin
        if (ehi) ebuf.push_back(edi);
        if (eho) ek++;
        if (ek == M) begin
          ebuf.delete();
          ek = 0;
        end
      end
      e_s_ready = reset && ebuf.size() < N;
      e_m_valid = reset && ebuf.size() == N;
      e_data_out = e_m_valid ? ebuf[ek] + 8'h10 : '0;
    end
  end

  bit h0, h1;

  initial begin
    s0_valid = 0;
    s0_data = '0;
    forever begin
      @(negedge clk);
      h0 = s0_valid && s0_ready;
      @(posedge clk);
      #2;
      if (h0 && sq0.size() > 0) void'(sq0.pop_front());
      s0_valid = sq0.size() > 0 && !hold0;
      s0_data = sq0.size() > 0 ? sq0[0] : '0;
    end
  end

  initial begin
    s1_valid = 0;
    s1_data = '0;
    forever begin
      @(negedge clk);
      h1 = s1_valid && s1_ready;
      @(posedge clk);
      #2;
      if (h1 && sq1.size() > 0) void'(sq1.pop_front());
      s1_valid = sq1.size() > 0 && !hold1;
      s1_data = sq1.size() > 0 ? sq1[0] : '0;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_vec(int p, logic [T-1:0] base);
    for (int j = 0; j < N; j++) begin
      if (p == 1) begin
        sq1.push_back(base + T'(j));
        exp1.push_back(base + T'(j) + 8'h10);
      end else begin
        sq0.push_back(base + T'(j));
        exp0.push_back(base + T'(j) + 8'h10);
      end
    end
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || exp0.size() > 0 ||
            exp1.size() > 0 || mp >= 0) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_done_timeout", n < budget, 1);
    cyc(2);
  endtask

  int alt_exp[4] = '{0, 1, 0, 1};
  logic [T-1:0] t1_exp[8] = '{8'h11, 8'h12, 8'h13, 8'h14,
                              8'h15, 8'h16, 8'h17, 8'h18};
  int saved, frz, n;

  initial begin
    reset = 0;
    m0_ready = 1;
    m1_ready = 1;
    hold0 = 0;
    hold1 = 0;
    cyc(2);
    chk("reset_outputs", all_hs, 0);
    reset = 1;
    cyc(2);
    chk("post_reset_idle", all_hs, 0);

    // Both requesters busy from reset: strict alternation from port 0.
    order.delete();
    push_vec(0, 8'h20);
    push_vec(1, 8'h40);
    push_vec(0, 8'h60);
    push_vec(1, 8'h80);
    wait_done(400);
    chk("alt_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("alt_order", i < order.size() ? order[i] : 9, alt_exp[i]);

    // Single requester, vector 1..8.
    order.delete();
    rxq0.delete();
    rxq1.delete();
    push_vec(0, 8'h01);
    wait_done(200);
    chk("t1_rx0_count", rxq0.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("t1_rx0_word", i < rxq0.size() ? rxq0[i] : 8'hxx, t1_exp[i]);
    chk("t1_rx1_none", rxq1.size(), 0);
    chk("t1_order", order.size() > 0 ? order[0] : 9, 0);

    // Result backpressure for 5 cycles mid-drain.
    saved = rxc0;
    push_vec(0, 8'hA0);
    n = 0;
    while (rxc0 < saved + 3 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t3_reach_word3", rxc0 >= saved + 3, 1);
    m0_ready = 0;
    frz = rxc0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_e_m_ready", e_m_ready, 0);
      chk("t3_e_m_valid", e_m_valid, 1);
      chk("t3_frozen", rxc0, frz);
    end
    @(posedge clk);
    #1;
    m0_ready = 1;
    wait_done(200);
    chk("t3_total", rxc0 - saved, 8);

    // Requester 1 stalls 3 cycles at word 4 while port 0 waits.
    order.delete();
    saved = txc1;
    push_vec(1, 8'hC0);
    n = 0;
    while (txc1 < saved + 4 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t4_reach_word4", txc1, saved + 4);
    hold1 = 1;
    push_vec(0, 8'hE0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_s0_ready", s0_ready, 0);
      chk("t4_e_s_valid", e_s_valid, 0);
      chk("t4_in_held", txc1, saved + 4);
    end
    @(posedge clk);
    #1;
    hold1 = 0;
    wait_done(300);
    chk("t4_first", order.size() > 0 ? order[0] : 9, 1);
    chk("t4_second", order.size() > 1 ? order[1] : 9, 0);

    // Asynchronous reset during drain word 3.
    saved = rxc0;
    push_vec(0, 8'h50);
    n = 0;
    while (rxc0 < saved + 3 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t5_reach_word3", rxc0 >= saved + 3, 1);
    chk("t5_busy_before", m0_valid, 1);
    #2;
    reset = 0;
    #1;
    chk("t5_async_outputs", all_hs, 0);
    sq0.delete();
    sq1.delete();
    exp0.delete();
    exp1.delete();
    cyc(2);
    chk("t5_held_outputs", all_hs, 0);
    reset = 1;
    cyc(1);
    order.delete();
    push_vec(0, 8'h30);
    push_vec(1, 8'h70);
    wait_done(300);
    chk("t5_tie_first", order.size() > 0 ? order[0] : 9, 0);
    chk("t5_tie_second", order.size() > 1 ? order[1] : 9, 1);

    // Three vectors total on port 0 and two on port 1 since reset.
    push_vec(0, 8'h90);
    push_vec(1, 8'hB0);
    push_vec(0, 8'hD0);
    wait_done(400);
    chk("model_dn0", dn0, 3);
    chk("model_dn1", dn1, 2);
`ifdef LAYER_ARB2_STATS_EN
    chk("done_cnt0", done_cnt0, 3);
    chk("done_cnt1", done_cnt1, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
